// File: rtl/lock_supervisor.sv
// Supervisory FSM for the two-key lock: judges enter strobes, times the
// open window, blinks an error indication and enforces a failure lockout.
module lock_supervisor #(
    parameter logic [1:0] CODE          = 2'b11,
    parameter int         OPEN_TICKS    = 16,
    parameter int         ERR_TICKS     = 8,
    parameter int         LOCKOUT_TICKS = 64,
    parameter int         MAX_FAILS     = 3,
    parameter int         BLINK_TICKS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       enter_pulse,
    input  logic       key_a,
    input  logic       key_b,
    output logic       open,
    output logic       error,
    output logic       lockout,
    output logic       led,
    output logic [3:0] fail_cnt
);

    localparam int MAX_OE = (OPEN_TICKS > ERR_TICKS) ? OPEN_TICKS : ERR_TICKS;
    localparam int MAX_T  = (MAX_OE > LOCKOUT_TICKS) ? MAX_OE : LOCKOUT_TICKS;
    localparam int TW     = $clog2(MAX_T + 1);
    localparam int BW     = $clog2(BLINK_TICKS + 1);

    localparam logic [TW-1:0] T_OPEN     = TW'(OPEN_TICKS);
    localparam logic [TW-1:0] T_ERR      = TW'(ERR_TICKS);
    localparam logic [TW-1:0] T_LOCK     = TW'(LOCKOUT_TICKS);
    localparam logic [TW-1:0] T_ONE      = TW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [3:0]    MAXF       = 4'(MAX_FAILS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_ERR,
        S_LOCK
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [BW-1:0] blink_cnt;

    // State, timers and all registered outputs advance together
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            blink_cnt <= '0;
            open      <= 1'b0;
            error     <= 1'b0;
            lockout   <= 1'b0;
            led       <= 1'b0;
            fail_cnt  <= 4'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (enter_pulse) begin
                        blink_cnt <= '0;
                        if ({key_a, key_b} == CODE) begin
                            state    <= S_OPEN;
                            open     <= 1'b1;
                            fail_cnt <= 4'd0;
                            timer    <= T_OPEN;
                        end else if (fail_cnt + 4'd1 >= MAXF) begin
                            state    <= S_LOCK;
                            error    <= 1'b1;
                            lockout  <= 1'b1;
                            led      <= 1'b1;
                            fail_cnt <= MAXF;
                            timer    <= T_LOCK;
                        end else begin
                            state    <= S_ERR;
                            error    <= 1'b1;
                            led      <= 1'b1;
                            fail_cnt <= fail_cnt + 4'd1;
                            timer    <= T_ERR;
                        end
                    end
                end
                S_OPEN: begin
                    if (tick) begin
                        if (timer == T_ONE) begin
                            state <= S_IDLE;
                            open  <= 1'b0;
                            timer <= '0;
                        end else begin
                            timer <= timer - T_ONE;
                        end
                    end
                end
                S_ERR, S_LOCK: begin
                    if (tick) begin
                        if (timer == T_ONE) begin
                            // lockout expiry forgives the failure history
                            if (state == S_LOCK) fail_cnt <= 4'd0;
                            state     <= S_IDLE;
                            error     <= 1'b0;
                            lockout   <= 1'b0;
                            led       <= 1'b0;
                            timer     <= '0;
                            blink_cnt <= '0;
                        end else begin
                            timer <= timer - T_ONE;
                            if (blink_cnt == BLINK_LAST) begin
                                blink_cnt <= '0;
                                led       <= ~led;
                            end else begin
                                blink_cnt <= blink_cnt + BW'(1);
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lock_supervisor.sv
// Scoreboard bench for lock_supervisor: a mode/elapsed-ticks reference model
// predicts every cycle's outputs; a monitor pops and compares after each edge.
module tb_lock_supervisor;

    localparam logic [1:0] CODE = 2'b11;
    localparam int OPEN_T  = 4;
    localparam int ERR_T   = 3;
    localparam int LOCK_T  = 8;
    localparam int MAXF    = 3;
    localparam int BLINK_T = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       enter_pulse = 1'b0;
    logic       key_a = 1'b0;
    logic       key_b = 1'b0;
    logic       open;
    logic       error;
    logic       lockout;
    logic       led;
    logic [3:0] fail_cnt;

    lock_supervisor #(
        .CODE(CODE),
        .OPEN_TICKS(OPEN_T),
        .ERR_TICKS(ERR_T),
        .LOCKOUT_TICKS(LOCK_T),
        .MAX_FAILS(MAXF),
        .BLINK_TICKS(BLINK_T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .enter_pulse(enter_pulse),
        .key_a(key_a),
        .key_b(key_b),
        .open(open),
        .error(error),
        .lockout(lockout),
        .led(led),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];
    string      phase = "reset";

    // reference model: mode 0 idle, 1 open, 2 error, 3 lockout
    int m_mode = 0;
    int m_elapsed = 0;
    int m_fails = 0;
    int cyc = 0;
    bit rand_tick = 0;

    function automatic int dur(input int mode);
        if (mode == 1) return OPEN_T;
        if (mode == 2) return ERR_T;
        return LOCK_T;
    endfunction

    function automatic logic [7:0] model_out();
        logic o, e, l, b;
        o = (m_mode == 1);
        e = (m_mode >= 2);
        l = (m_mode == 3);
        b = (m_mode >= 2) && (((m_elapsed / BLINK_T) % 2) == 0);
        return {o, e, l, b, 4'(m_fails)};
    endfunction

    task automatic model_step(input logic r, input logic en,
                              input logic [1:0] k, input logic t);
        if (r) begin
            m_mode = 0;
            m_elapsed = 0;
            m_fails = 0;
        end else if (m_mode == 0) begin
            if (en) begin
                m_elapsed = 0;
                if (k == CODE) begin
                    m_mode = 1;
                    m_fails = 0;
                end else if (m_fails + 1 >= MAXF) begin
                    m_mode = 3;
                    m_fails = MAXF;
                end else begin
                    m_mode = 2;
                    m_fails = m_fails + 1;
                end
            end
        end else if (t) begin
            m_elapsed++;
            if (m_elapsed == dur(m_mode)) begin
                if (m_mode == 3) m_fails = 0;
                m_mode = 0;
                m_elapsed = 0;
            end
        end
    endtask

    // drive one cycle at the negedge and queue the post-edge expectation
    task automatic drive(input logic r, input logic en, input logic [1:0] k);
        logic t;
        @(negedge clk);
        if (rand_tick) t = ($urandom % 3) == 0;
        else t = (cyc % 4) == 3;
        cyc++;
        rst = r;
        enter_pulse = en;
        {key_a, key_b} = k;
        tick = t;
        model_step(r, en, k, t);
        exp_q.push_back(model_out());
        name_q.push_back(phase);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'($urandom));
    endtask

    // monitor: compare every registered output just after each edge
    initial begin
        logic [7:0] exp;
        logic [7:0] act;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {open, error, lockout, led, fail_cnt};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL %s @%0t: {open,error,lockout,led,fail_cnt} got %b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
                             nm, $time, act[7], act[6], act[5], act[4], act[3:0],
                             exp[7], exp[6], exp[5], exp[4], exp[3:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        phase = "reset";
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 2'b11);
        idle(2);

        phase = "correct_entry";
        drive(1'b0, 1'b1, 2'b11);
        idle(22);

        phase = "single_fail";
        drive(1'b0, 1'b1, 2'b01);
        idle(16);
        phase = "fail_cleared";
        drive(1'b0, 1'b1, 2'b11);
        idle(20);

        phase = "lockout";
        for (int f = 0; f < 3; f++) begin
            drive(1'b0, 1'b1, 2'b10);
            idle(16);
        end
        phase = "enter_in_lock";
        drive(1'b0, 1'b1, 2'b11);
        idle(24);

        phase = "ignored_enter";
        drive(1'b0, 1'b1, 2'b11);
        idle(3);
        drive(1'b0, 1'b1, 2'b00);
        idle(20);

        phase = "reset_mid_lock";
        for (int f = 0; f < 3; f++) begin
            drive(1'b0, 1'b1, 2'b00);
            idle(16);
        end
        drive(1'b0, 1'b1, 2'b01);
        idle(10);
        drive(1'b1, 1'b0, 2'b00);
        idle(2);
        drive(1'b0, 1'b1, 2'b11);
        idle(20);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            logic r, e;
            logic [1:0] k;
            if (i == 1500) rand_tick = 1;
            r = ($urandom % 400) == 0;
            e = ($urandom % 5) == 0;
            k = (($urandom % 2) == 0) ? CODE : 2'($urandom);
            drive(r, e, k);
        end
        idle(2);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
